// File: rtl/led_blinker_pkg.sv
// Shared definitions for the LED blinker: channel mode encodings and default
// blink timing.
//
// Optional feature: define LED_BLINKER_DIM_EN to enable PWM dimming in
// led_blinker.
package led_blinker_pkg;

  // Per-channel mode encodings (2 bits per channel)
  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  // 500 ms half-period at 50 MHz
  localparam int unsigned TICK_DIV_DEFAULT = 25_000_000;

  // Width of the free-running dimming PWM counter
  localparam int unsigned PWM_W = 4;

endpackage

// File: rtl/led_tick_gen.sv
// Blink timebase: prescaler counting 0..TICK_DIV-1 plus a shared phase bit that
// toggles on every wrap.
//
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset
//   clr     - synchronous clear of prescaler and phase (has priority over tick)
//   tick_c  - combinational, high for the cycle the prescaler equals TICK_DIV-1
//   phase   - registered, 1 = lit half-period
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick_c,
  output logic phase
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0] cnt_q;

  assign tick_c = (cnt_q == PRE_W'(TICK_DIV - 1));

  // Prescaler and phase; a clear restarts all channels in sync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
      phase <= 1'b0;
    end else if (tick_c) begin
      cnt_q <= '0;
      phase <= ~phase;
    end else begin
      cnt_q <= cnt_q + PRE_W'(1);
    end
  end

endmodule

// File: rtl/led_blinker.sv
// Multi-channel LED blinker. Each channel is off, steadily on, blinking from a
// shared timebase, or emitting a counted burst of lit half-periods.
//
// Optional feature: `define LED_BLINKER_DIM_EN adds a 4-bit dim input that
// gates every lit period with a free-running PWM (lit while counter < dim).
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   load     - one-cycle pulse capturing mode and burst_n
//   mode     - per-channel mode, channel i at [2i+1:2i]
//   burst_n  - lit-pulse count for burst channels
//   dim      - PWM duty (only with LED_BLINKER_DIM_EN)
//   o_led    - registered LED drive, 1 = lit
//   busy     - registered, high while any burst channel has pulses remaining
module led_blinker
  import led_blinker_pkg::*;
#(
  parameter int unsigned N_CH     = 3,
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [2*N_CH-1:0]   mode,
  input  logic [CNT_W-1:0]    burst_n,
`ifdef LED_BLINKER_DIM_EN
  input  logic [PWM_W-1:0]    dim,
`endif
  output logic [N_CH-1:0]     o_led,
  output logic                busy
);

  logic            tick_c;
  logic            phase_q;
  logic            fall_c;
  logic            lit_on_c;
  logic [N_CH-1:0] led_nxt_c;
  logic [N_CH-1:0] busy_ch_c;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (load),
    .tick_c (tick_c),
    .phase  (phase_q)
  );

  // End of a lit half-period; load suppresses it so a coincident load never decrements
  assign fall_c = tick_c & phase_q & ~load;

`ifdef LED_BLINKER_DIM_EN
  logic [PWM_W-1:0] pwm_q;

  // Free-running dimming counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + PWM_W'(1);
    end
  end

  assign lit_on_c = (pwm_q < dim);
`else
  assign lit_on_c = 1'b1;
`endif

  // Per-channel mode and remaining burst count
  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] rem_q;
    logic             led_c;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_q <= MODE_OFF;
        rem_q  <= '0;
      end else if (load) begin
        mode_q <= mode[2*i +: 2];
        rem_q  <= (mode[2*i +: 2] == MODE_BURST) ? burst_n : '0;
      end else if (fall_c && (mode_q == MODE_BURST) && (rem_q != '0)) begin
        rem_q  <= rem_q - CNT_W'(1);
      end
    end

    // Next LED value from the current channel state
    always_comb begin
      led_c = 1'b0;
      case (mode_q)
        MODE_ON:    led_c = lit_on_c;
        MODE_BLINK: led_c = phase_q & lit_on_c;
        MODE_BURST: led_c = phase_q & (rem_q != '0) & lit_on_c;
        default:    led_c = 1'b0;
      endcase
    end

    assign led_nxt_c[i] = led_c;
    assign busy_ch_c[i] = (mode_q == MODE_BURST) && (rem_q != '0);
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_led <= '0;
      busy  <= 1'b0;
    end else begin
      o_led <= led_nxt_c;
      busy  <= |busy_ch_c;
    end
  end

endmodule

// File: tb/tb_led_blinker.sv
// Bench for led_blinker (default build, TICK_DIV = 4, N_CH = 3).
// An analytic model predicts {busy, o_led} one edge ahead into a scoreboard
// queue; the monitor pops and compares after every rising edge.
module tb_led_blinker;

  localparam int unsigned N_CH  = 3;
  localparam int unsigned TDIV  = 4;
  localparam int unsigned CNT_W = 4;

  logic              clk;
  logic              rst_n;
  logic              load;
  logic [2*N_CH-1:0] mode;
  logic [CNT_W-1:0]  burst_n;
`ifdef LED_BLINKER_DIM_EN
  logic [3:0]        dim;
`endif
  logic [N_CH-1:0]   o_led;
  logic              busy;

  int n_vec;
  int n_err;

  led_blinker #(
    .N_CH     (N_CH),
    .TICK_DIV (TDIV),
    .CNT_W    (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .mode    (mode),
    .burst_n (burst_n),
`ifdef LED_BLINKER_DIM_EN
    .dim     (dim),
`endif
    .o_led   (o_led),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model state: captured mode/count and cycles elapsed since the last load
  logic [2*N_CH-1:0] m_mode;
  int                m_n;
  int                m_j;
  logic [N_CH:0]     sb_q[$];
  logic              mon_en;

  function automatic logic [N_CH:0] predict();
    logic [N_CH:0] r;
    logic [1:0]    md;
    int            ph, done, rem;
    r    = '0;
    ph   = (m_j / TDIV) % 2;
    done = m_j / (2 * TDIV);
    rem  = (m_n > done) ? (m_n - done) : 0;
    for (int i = 0; i < int'(N_CH); i++) begin
      md = m_mode[2*i +: 2];
      case (md)
        2'b01: r[i] = 1'b1;
        2'b10: r[i] = (ph == 1);
        2'b11: r[i] = (ph == 1) && (rem > 0);
        default: r[i] = 1'b0;
      endcase
      if (md == 2'b11 && rem > 0) r[N_CH] = 1'b1;
    end
    return r;
  endfunction

  // Monitor / scoreboard
  always @(posedge clk) begin
    logic [N_CH:0] exp_v;
    #1;
    if (mon_en) begin
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", 32'd0, 32'd1);
      end else begin
        exp_v = sb_q.pop_front();
        check_val("o_led", 32'(o_led), 32'(exp_v[N_CH-1:0]));
        check_val("busy",  32'(busy),  32'(exp_v[N_CH]));
      end
      if (!rst_n) begin
        m_mode = '0; m_n = 0; m_j = 0;
      end else if (load) begin
        m_mode = mode; m_n = int'(burst_n); m_j = 0;
      end else begin
        m_j++;
      end
      sb_q.push_back(predict());
    end
  end

  task automatic do_load(input logic [2*N_CH-1:0] md, input logic [CNT_W-1:0] bn);
    @(negedge clk);
    load = 1'b1; mode = md; burst_n = bn;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Idle cycles with junk on mode/burst_n, which must be ignored while load is low
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      mode    = (2*N_CH)'($urandom);
      burst_n = CNT_W'($urandom);
    end
  endtask

  initial begin
    int pulses;
    logic prev, seen_busy;
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; load = 1'b0; mode = '0; burst_n = '0;
`ifdef LED_BLINKER_DIM_EN
    dim = 4'd15;
`endif
    m_mode = '0; m_n = 0; m_j = 0;
    sb_q.push_back('0);
    mon_en = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    check_val("reset_led", 32'(o_led), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    // ch2 on, ch1 blink, ch0 off
    do_load(6'b01_10_00, 4'd0);
    idle(30);

    // Asynchronous reset mid-blink
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_led", 32'(o_led), 32'd0);
    check_val("async_rst_busy", 32'(busy), 32'd0);
    sb_q.delete();
    sb_q.push_back('0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Burst of 3 on ch0: count lit pulses independently
    do_load(6'b00_00_11, 4'd3);
    pulses = 0; prev = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_led[0] && !prev) pulses++;
      prev = o_led[0];
    end
    check_val("burst3_pulses", 32'(pulses), 32'd3);
    check_val("burst3_busy_end", 32'(busy), 32'd0);

    // Burst of 0: never lit, never busy
    do_load(6'b00_00_11, 4'd0);
    seen_busy = 1'b0; prev = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      seen_busy = seen_busy | busy;
      prev = prev | o_led[0];
    end
    check_val("burst0_busy", 32'(seen_busy), 32'd0);
    check_val("burst0_led", 32'(prev), 32'd0);

    // Burst of 5, re-load with 2 on the tick after the first pulse
    do_load(6'b00_00_11, 4'd5);
    repeat (11) @(negedge clk);
    do_load(6'b00_00_11, 4'd2);
    pulses = 0; prev = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (o_led[0] && !prev) pulses++;
      prev = o_led[0];
    end
    check_val("reload_pulses", 32'(pulses), 32'd2);

    // Random loads, including mid-burst aborts
    for (int r = 0; r < 10; r++) begin
      do_load((2*N_CH)'($urandom_range(0, 63)), CNT_W'($urandom_range(0, 15)));
      idle($urandom_range(1, 40));
    end
    idle(4);

    @(negedge clk);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
